gcd_axil_regs: RTL and testbench

- AXI4-Lite slave register front-end that sits directly upstream of the GCD core in the AXI-Lite example design.
- Software writes operands A and B, then writes a start bit.
- The block launches both operands on the core's valid/ready input channels and consumes the core's result channel.
- The result and a status word are made readable over AXI4-Lite.

---
 rtl/gcd_axil_regs.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_gcd_axil_regs.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_axil_regs.sv
// AXI4-Lite register front-end for the GCD core: operand and control registers,
// valid/ready launch of both operands and capture of the core's result.
module gcd_axil_regs #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   s_awaddr,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [DW-1:0]   s_wdata,
  input  logic [DW/8-1:0] s_wstrb,
  input  logic            s_wvalid,
  output logic            s_wready,
  output logic [1:0]      s_bresp,
  output logic            s_bvalid,
  input  logic            s_bready,
  input  logic [AW-1:0]   s_araddr,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [DW-1:0]   s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [DW-1:0]   A_data,
  output logic            A_valid,
  input  logic            A_ready,
  output logic [DW-1:0]   B_data,
  output logic            B_valid,
  input  logic            B_ready,
  input  logic [DW-1:0]   GCD_data,
  input  logic            GCD_valid,
  output logic            GCD_ready
);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {L_IDLE, L_SEND, L_WAIT} l_state_e;

  localparam logic [2:0] REG_OPA    = 3'd0;
  localparam logic [2:0] REG_OPB    = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_RESULT = 3'd4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  l_state_e          l_state_q, l_state_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]        awidx_q, awidx_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [DW-1:0]     a_data_q, a_data_d, b_data_q, b_data_d;
  logic              gcd_ready_q, gcd_ready_d;
  logic [DW-1:0]     opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic              done_q, done_d, a_sent_q, a_sent_d, b_sent_q, b_sent_d;
  logic              err_q, err_d;

  logic              aw_hs, w_hs, ar_hs, wr_fire, start, clr, rd_ok;
  logic [2:0]        wr_idx;
  logic [DW-1:0]     wr_data, rd_word, status;
  logic [DW/8-1:0]   wr_strb;
  logic              unused_addr_lsbs;

  // Registers are word aligned; the byte-offset bits carry no information.
  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign aw_hs   = s_awvalid && awready_q;
  assign w_hs    = s_wvalid && wready_q;
  assign ar_hs   = s_arvalid && arready_q;
  assign wr_idx  = aw_hs ? s_awaddr[4:2] : awidx_q;
  assign wr_data = w_hs ? s_wdata : wdata_q;
  assign wr_strb = w_hs ? s_wstrb : wstrb_q;
  // Commit once both halves are present, whether just handshaken or latched earlier.
  assign wr_fire = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign start   = wr_fire && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[0];
  assign clr     = wr_fire && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[1];
  assign status  = {{(DW-5){1'b0}}, err_q, b_sent_q, a_sent_q, done_q, (l_state_q != L_IDLE)};

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_fire) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = (wr_idx <= REG_RESULT) ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_awaddr[4:2];
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
          end
          awready_d = !(aw_held_q || aw_hs);
          wready_d  = !(w_held_q || w_hs);
        end
      end
      W_RESP: begin
        if (s_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_word   = '0;
    rd_ok     = 1'b1;
    case (s_araddr[4:2])
      REG_OPA:    rd_word = opa_q;
      REG_OPB:    rd_word = opb_q;
      REG_CTRL:   rd_word = '0;
      REG_STATUS: rd_word = status;
      REG_RESULT: rd_word = result_q;
      default:    rd_ok   = 1'b0;
    endcase
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    l_state_d   = l_state_q;
    a_valid_d   = a_valid_q;
    b_valid_d   = b_valid_q;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    gcd_ready_d = gcd_ready_q;
    result_d    = result_q;
    done_d      = done_q;
    a_sent_d    = a_sent_q;
    b_sent_d    = b_sent_q;
    err_d       = err_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    for (int unsigned i = 0; i < DW/8; i++) begin
      if (wr_fire && (wr_idx == REG_OPA) && wr_strb[i]) opa_d[8*i +: 8] = wr_data[8*i +: 8];
      if (wr_fire && (wr_idx == REG_OPB) && wr_strb[i]) opb_d[8*i +: 8] = wr_data[8*i +: 8];
    end
    // CLR is applied before any launch or result capture so those set-events win.
    if (clr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    case (l_state_q)
      L_IDLE: begin
        if (start) begin
          a_data_d  = opa_q;
          b_data_d  = opb_q;
          a_valid_d = 1'b1;
          b_valid_d = 1'b1;
          done_d    = 1'b0;
          a_sent_d  = 1'b0;
          b_sent_d  = 1'b0;
          l_state_d = L_SEND;
        end
      end
      L_SEND: begin
        if (a_valid_q && A_ready) begin
          a_valid_d = 1'b0;
          a_sent_d  = 1'b1;
        end
        if (b_valid_q && B_ready) begin
          b_valid_d = 1'b0;
          b_sent_d  = 1'b1;
        end
        if (a_sent_d && b_sent_d) begin
          gcd_ready_d = 1'b1;
          l_state_d   = L_WAIT;
        end
      end
      L_WAIT: begin
        if (GCD_valid && gcd_ready_q) begin
          result_d    = GCD_data;
          done_d      = 1'b1;
          gcd_ready_d = 1'b0;
          l_state_d   = L_IDLE;
        end
      end
      default: l_state_d = L_IDLE;
    endcase
    if (start && (l_state_q != L_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      l_state_q   <= L_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awidx_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      gcd_ready_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      a_sent_q    <= 1'b0;
      b_sent_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      l_state_q   <= l_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awidx_q     <= awidx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      gcd_ready_q <= gcd_ready_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      done_q      <= done_d;
      a_sent_q    <= a_sent_d;
      b_sent_q    <= b_sent_d;
      err_q       <= err_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign A_valid   = a_valid_q;
  assign A_data    = a_data_q;
  assign B_valid   = b_valid_q;
  assign B_data    = b_data_q;
  assign GCD_ready = gcd_ready_q;

endmodule

// File: tb/tb_gcd_axil_regs.sv
// Bench for gcd_axil_regs: randomized AXI-Lite traffic and a behavioural GCD core,
// checked against a register-level reference model.
module tb_gcd_axil_regs;

  localparam logic [4:0] A_OPA = 5'h00, A_OPB = 5'h04, A_CTRL = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h0C, A_RESULT = 5'h10;

  logic        clk, rst;
  logic [4:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] A_data, B_data, GCD_data;
  logic        A_valid, A_ready, B_valid, B_ready, GCD_valid, GCD_ready;

  int n_checks = 0;
  int n_fail = 0;
  bit core_slow = 0;
  bit hold_ready_low = 0;

  // Reference model of the software-visible state
  logic [31:0] opa_m, opb_m, result_m, pend_m;
  bit done_m, err_m, sent_m, busy_m;

  gcd_axil_regs #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready),
    .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready),
    .GCD_data(GCD_data), .GCD_valid(GCD_valid), .GCD_ready(GCD_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                       input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] status_m();
    return {27'd0, err_m, sent_m, sent_m, done_m, busy_m};
  endfunction

  // Behavioural core: random input readies, result after a short (or long) delay.
  initial begin : core_model
    logic [31:0] ca, cb, a_smp, b_smp;
    bit got_a, got_b, fa, fb, fg;
    int dly;
    A_ready = 0; B_ready = 0; GCD_valid = 0; GCD_data = '0;
    got_a = 0; got_b = 0; dly = 0; ca = '0; cb = '0;
    forever begin
      fa = A_valid && A_ready;
      fb = B_valid && B_ready;
      fg = GCD_valid && GCD_ready;
      a_smp = A_data;
      b_smp = B_data;
      tick();
      if (rst) begin
        A_ready = 0; B_ready = 0; GCD_valid = 0; got_a = 0; got_b = 0;
      end else begin
        if (fa) begin got_a = 1; ca = a_smp; end
        if (fb) begin got_b = 1; cb = b_smp; end
        if (fg) begin
          GCD_valid = 0; got_a = 0; got_b = 0;
        end else if (got_a && got_b && !GCD_valid) begin
          if (fa || fb) dly = core_slow ? 60 : int'($urandom_range(0, 3));
          if (dly == 0) begin
            GCD_valid = 1;
            GCD_data = gcd_ref(ca, cb);
          end else dly--;
        end
        A_ready = !got_a && !hold_ready_low && ($urandom_range(0, 1) == 1);
        B_ready = !got_b && !hold_ready_low && ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic wait_b(output logic [1:0] resp);
    int c;
    s_bready = 1; c = 0;
    while (!s_bvalid && c < 100) begin tick(); c++; end
    if (!s_bvalid) check("bvalid_timeout", 0, 1);
    resp = s_bresp;
    tick();
    s_bready = 0;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    int c;
    bit aw_done, w_done, aw_f, w_f;
    aw_done = 0; w_done = 0; c = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    while (!(aw_done && w_done) && c < 100) begin
      s_awvalid = !aw_done && (c >= aw_dly);
      s_wvalid  = !w_done && (c >= w_dly);
      aw_f = s_awvalid && s_awready;
      w_f  = s_wvalid && s_wready;
      tick();
      c++;
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int c;
    bit f;
    s_araddr = addr; s_arvalid = 1; c = 0; f = 0;
    while (!f && c < 100) begin
      f = s_arready;
      tick();
      c++;
    end
    s_arvalid = 0;
    if (!f) check("ar_timeout", 0, 1);
    check("rd_latency", s_rvalid, 1);
    data = s_rdata;
    repeat ($urandom_range(0, 2)) tick();
    check("rd_hold", s_rdata, data);
    resp = s_rresp;
    s_rready = 1;
    tick();
    s_rready = 0;
  endtask

  task automatic rcheck(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(addr, d, r);
    check(tag, d, exp);
    check({tag, "_rresp"}, r, (addr[4:2] <= 3'd4) ? 2'b00 : 2'b10);
  endtask

  task automatic mwrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input string tag);
    logic [1:0] resp;
    axi_write(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp);
    check({tag, "_bresp"}, resp, (addr[4:2] <= 3'd4) ? 2'b00 : 2'b10);
    case (addr[4:2])
      3'd0: opa_m = merge(opa_m, data, strb);
      3'd1: opb_m = merge(opb_m, data, strb);
      3'd2: if (strb[0]) begin
        if (data[1]) begin done_m = 0; err_m = 0; end
        if (data[0]) begin
          if (busy_m) err_m = 1;
          else begin
            pend_m = gcd_ref(opa_m, opb_m);
            busy_m = 1; done_m = 0; sent_m = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic poll_done(input string tag);
    logic [31:0] st;
    logic [1:0] r;
    int n;
    st = 32'd1; n = 0;
    while (st[0] && n < 300) begin axi_read(A_STATUS, st, r); n++; end
    if (st[0]) check({tag, "_done_timeout"}, 0, 1);
    result_m = pend_m; done_m = 1; sent_m = 1; busy_m = 0;
    rcheck({tag, "_status"}, A_STATUS, status_m());
    rcheck({tag, "_result"}, A_RESULT, result_m);
  endtask

  task automatic model_reset();
    opa_m = '0; opb_m = '0; result_m = '0; pend_m = '0;
    done_m = 0; err_m = 0; sent_m = 0; busy_m = 0;
  endtask

  initial begin
    logic [31:0] d, a, b, k;
    logic [3:0] strb;
    logic [1:0] resp;
    rst = 0;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    model_reset();
    #2 rst = 1;
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_avalid", A_valid, 0);
    check("rst_bvalid_core", B_valid, 0);
    check("rst_gcd_ready", GCD_ready, 0);
    check("rst_adata", A_data, 0);
    repeat (3) tick();
    rst = 0;
    tick();
    check("idle_awready", s_awready, 1);
    check("idle_arready", s_arready, 1);
    rcheck("rst_status", A_STATUS, 0);

    // Normal launch with a slow core so BUSY is observable
    core_slow = 1;
    mwrite(A_OPA, 32'd48, 4'hF, "norm_opa");
    mwrite(A_OPB, 32'd18, 4'hF, "norm_opb");
    mwrite(A_CTRL, 32'd1, 4'hF, "norm_start");
    axi_read(A_STATUS, d, resp);
    check("norm_busy", d[0], 1);
    poll_done("norm");
    check("norm_status_0e", status_m(), 32'h0E);
    core_slow = 0;

    mwrite(A_OPA, 32'd0, 4'hF, "zero_opa");
    mwrite(A_OPB, 32'd24, 4'hF, "zero_opb");
    mwrite(A_CTRL, 32'd1, 4'hF, "zero_start");
    poll_done("zero");

    // START while busy: sticky ERR, first run's result, later operand write harmless
    core_slow = 1;
    mwrite(A_OPA, 32'd84, 4'hF, "busy_opa");
    mwrite(A_OPB, 32'd36, 4'hF, "busy_opb");
    mwrite(A_CTRL, 32'd1, 4'hF, "busy_start1");
    mwrite(A_OPA, 32'd35, 4'hF, "busy_opa2");
    mwrite(A_CTRL, 32'd1, 4'hF, "busy_start2");
    poll_done("busy");
    rcheck("busy_opa_rd", A_OPA, 32'd35);
    core_slow = 0;
    mwrite(A_CTRL, 32'd2, 4'hF, "clr");
    rcheck("clr_status", A_STATUS, status_m());

    // Bus corner cases
    mwrite(A_STATUS, 32'hFFFF_FFFF, 4'hF, "ro_write");
    rcheck("ro_status", A_STATUS, status_m());
    mwrite(5'h14, 32'h1234_5678, 4'hF, "bad_write");
    rcheck("bad_read", 5'h1C, 32'd0);
    rcheck("ctrl_read", A_CTRL, 32'd0);

    s_awaddr = A_OPB; s_wdata = 32'h0000_0ABC; s_wstrb = 4'hF; s_wvalid = 1;
    check("skew_wready", s_wready, 1);
    tick();
    s_wvalid = 0;
    repeat (2) begin
      check("skew_wready_low", s_wready, 0);
      check("skew_awready_high", s_awready, 1);
      check("skew_no_bvalid", s_bvalid, 0);
      tick();
    end
    s_awvalid = 1;
    tick();
    s_awvalid = 0;
    check("skew_bvalid", s_bvalid, 1);
    wait_b(resp);
    check("skew_bresp", resp, 0);
    opb_m = 32'h0000_0ABC;
    rcheck("skew_opb", A_OPB, opb_m);

    s_awaddr = A_OPA; s_wdata = 32'h1111_1111; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    check("stall_bvalid", s_bvalid, 1);
    s_wdata = 32'h2222_2222; s_awvalid = 1; s_wvalid = 1;
    repeat (5) begin
      check("stall_awready", s_awready, 0);
      check("stall_wready", s_wready, 0);
      check("stall_bvalid_hold", s_bvalid, 1);
      tick();
    end
    s_bready = 1;
    tick();
    s_bready = 0;
    check("stall_released", s_awready, 1);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    check("stall_second_bvalid", s_bvalid, 1);
    wait_b(resp);
    opa_m = 32'h2222_2222;
    rcheck("stall_opa", A_OPA, opa_m);

    mwrite(A_OPA, 32'hFFFF_FFFF, 4'hF, "strb_all");
    mwrite(A_OPA, 32'h0000_0012, 4'b0001, "strb_lane0");
    rcheck("strb_ffffff12", A_OPA, 32'hFFFF_FF12);
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      strb = 4'($urandom);
      mwrite((i % 2 == 0) ? A_OPA : A_OPB, d, strb, "strb_rand");
      rcheck("strb_rand_opa", A_OPA, opa_m);
      rcheck("strb_rand_opb", A_OPB, opb_m);
    end

    // Randomized operand runs
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(1, 60);
      a = (i % 4 == 3) ? $urandom : k * $urandom_range(0, 3000);
      b = (i % 4 == 3) ? $urandom : k * $urandom_range(1, 3000);
      mwrite(A_OPA, a, 4'hF, "rnd_opa");
      mwrite(A_OPB, b, 4'hF, "rnd_opb");
      rcheck("rnd_opa_rd", A_OPA, opa_m);
      rcheck("rnd_opb_rd", A_OPB, opb_m);
      mwrite(A_CTRL, ($urandom_range(0, 1) == 1) ? 32'd3 : 32'd1, 4'hF, "rnd_start");
      poll_done("rnd");
    end

    // Asynchronous reset while the operands are stuck in L_SEND
    hold_ready_low = 1;
    mwrite(A_OPA, 32'd100, 4'hF, "rmid_opa");
    mwrite(A_OPB, 32'd75, 4'hF, "rmid_opb");
    mwrite(A_CTRL, 32'd1, 4'hF, "rmid_start");
    tick();
    check("rmid_avalid_pre", A_valid, 1);
    check("rmid_bvalid_pre", B_valid, 1);
    #3 rst = 1;
    #1;
    check("rmid_avalid", A_valid, 0);
    check("rmid_bvalid", B_valid, 0);
    check("rmid_awready", s_awready, 0);
    check("rmid_arready", s_arready, 0);
    check("rmid_gcd_ready", GCD_ready, 0);
    repeat (2) tick();
    rst = 0;
    hold_ready_low = 0;
    model_reset();
    tick();
    rcheck("rmid_opa", A_OPA, 0);
    rcheck("rmid_opb", A_OPB, 0);
    rcheck("rmid_status", A_STATUS, 0);
    rcheck("rmid_result", A_RESULT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
